// File: rtl/counter_stream_checker_pkg.sv
// Shared types and helpers for the counter stream checker.
package counter_stream_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  // Common width for saturating arithmetic; callers zero-extend into it.
  localparam int SAT_W = 32;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_value);
    sat_inc = (value == max_value) ? value : value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/counter_period_meter.sv
// Measures the spacing, in valid samples, between consecutive pulses.
module counter_period_meter
  import counter_stream_checker_pkg::*;
#(
  parameter int PERIOD    = 100,
  parameter int ERR_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_pulse,
  input  logic                 i_clear,
  output logic [ERR_WIDTH-1:0] o_period_meas,
  output logic                 o_period_err
);

  localparam logic [SAT_W-1:0] MAX_VAL = SAT_W'({ERR_WIDTH{1'b1}});

  logic [ERR_WIDTH-1:0] r_since;
  logic                 r_armed;
  logic [ERR_WIDTH-1:0] r_period_meas;
  logic                 r_period_err;
  logic [SAT_W-1:0]     w_since_inc;

  // Spacing including the current sample; saturated so a long gap never wraps.
  assign w_since_inc = sat_inc(SAT_W'(r_since), MAX_VAL);

  // Count samples since the last pulse; first pulse only arms the measurement.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_since       <= '0;
      r_armed       <= 1'b0;
      r_period_meas <= '0;
      r_period_err  <= 1'b0;
    end else if (i_clear) begin
      r_since       <= '0;
      r_armed       <= 1'b0;
      r_period_meas <= '0;
      r_period_err  <= 1'b0;
    end else begin
      r_period_err <= 1'b0;
      if (i_valid) begin
        if (i_pulse) begin
          if (r_armed) begin
            r_period_meas <= ERR_WIDTH'(w_since_inc);
            r_period_err  <= (w_since_inc != SAT_W'(PERIOD));
          end
          r_since <= '0;
          r_armed <= 1'b1;
        end else begin
          r_since <= ERR_WIDTH'(w_since_inc);
        end
      end
    end
  end

  assign o_period_meas = r_period_meas;
  assign o_period_err  = r_period_err;

endmodule

// File: rtl/counter_stream_checker.sv
// Checks a counter's output stream: +1 per valid sample, overflow and pulse period.
module counter_stream_checker
  import counter_stream_checker_pkg::*;
#(
  parameter int COUNT_WIDTH = 12,
  parameter int PERIOD      = 100,
  parameter int LOCK_COUNT  = 4,
  parameter int MISS_LIMIT  = 3,
  parameter int ERR_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   overflow_in,
  input  logic                   pulse_in,
  input  logic                   clear,
  output logic                   locked,
  output logic                   seq_err,
  output logic                   lock_lost,
  output logic [ERR_WIDTH-1:0]   err_count,
  output logic [ERR_WIDTH-1:0]   ovf_count,
  output logic [ERR_WIDTH-1:0]   period_meas,
  output logic                   period_err
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  // Comparing the pre-increment value against LIMIT-1 equals "value+1 == LIMIT".
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
  localparam logic [SAT_W-1:0]  MAX_VAL   = SAT_W'({ERR_WIDTH{1'b1}});

  state_t               r_state;
  logic [COUNT_WIDTH-1:0] r_expected;
  logic [RUN_W-1:0]     r_run;
  logic [MISS_W-1:0]    r_miss;
  logic                 r_locked;
  logic                 r_seq_err;
  logic                 r_lock_lost;
  logic [ERR_WIDTH-1:0] r_err_count;
  logic [ERR_WIDTH-1:0] r_ovf_count;

  logic                   w_match;
  logic [COUNT_WIDTH-1:0] w_seed;
  logic                   w_err_evt;

  assign w_match   = (count_in == r_expected);
  assign w_seed    = count_in + COUNT_WIDTH'(1);
  assign w_err_evt = valid_in && (r_state == ST_LOCKED) && !w_match;

  // Lock FSM: seed, acquire LOCK_COUNT increments, flywheel through misses while locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_expected  <= '0;
      r_run       <= '0;
      r_miss      <= '0;
      r_locked    <= 1'b0;
      r_seq_err   <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_seq_err   <= 1'b0;
      r_lock_lost <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_expected <= w_seed;
            r_run      <= '0;
            r_state    <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (valid_in) begin
            if (w_match) begin
              r_expected <= r_expected + COUNT_WIDTH'(1);
              r_run      <= r_run + RUN_W'(1);
              if (r_run == RUN_LAST) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_miss   <= '0;
              end
            end else begin
              r_expected <= w_seed;
              r_run      <= '0;
            end
          end
        end
        ST_LOCKED: begin
          if (valid_in) begin
            r_expected <= r_expected + COUNT_WIDTH'(1);
            if (w_match) begin
              r_miss <= '0;
            end else begin
              r_seq_err <= 1'b1;
              r_miss    <= r_miss + MISS_W'(1);
              if (r_miss == MISS_LAST) begin
                r_state     <= ST_LOST;
                r_locked    <= 1'b0;
                r_lock_lost <= 1'b1;
              end
            end
          end
        end
        default: begin
          // ST_LOST: one-cycle stay, any sample arriving here is dropped.
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating statistics; clear overrides a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_err_count <= '0;
      r_ovf_count <= '0;
    end else begin
      if (w_err_evt)
        r_err_count <= ERR_WIDTH'(sat_inc(SAT_W'(r_err_count), MAX_VAL));
      if (valid_in && overflow_in)
        r_ovf_count <= ERR_WIDTH'(sat_inc(SAT_W'(r_ovf_count), MAX_VAL));
    end
  end

  counter_period_meter #(
    .PERIOD    (PERIOD),
    .ERR_WIDTH (ERR_WIDTH)
  ) u_period (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (valid_in),
    .i_pulse       (pulse_in),
    .i_clear       (clear),
    .o_period_meas (period_meas),
    .o_period_err  (period_err)
  );

  assign locked    = r_locked;
  assign seq_err   = r_seq_err;
  assign lock_lost = r_lock_lost;
  assign err_count = r_err_count;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Scoreboard bench for counter_stream_checker (plus a narrow-counter instance for saturation).
module tb_counter_stream_checker;

  logic        clk = 1'b0;
  logic        rst, valid_in, overflow_in, pulse_in, clear;
  logic [11:0] count_in;

  logic        locked, seq_err, lock_lost, period_err;
  logic [15:0] err_count, ovf_count, period_meas;

  logic        s_locked, s_seq_err, s_lock_lost, s_period_err;
  logic [3:0]  s_err_count, s_ovf_count, s_period_meas;

  always #5 clk = ~clk;

  counter_stream_checker dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .count_in(count_in),
    .overflow_in(overflow_in), .pulse_in(pulse_in), .clear(clear),
    .locked(locked), .seq_err(seq_err), .lock_lost(lock_lost),
    .err_count(err_count), .ovf_count(ovf_count),
    .period_meas(period_meas), .period_err(period_err)
  );

  counter_stream_checker #(.ERR_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst), .valid_in(valid_in), .count_in(count_in),
    .overflow_in(overflow_in), .pulse_in(pulse_in), .clear(clear),
    .locked(s_locked), .seq_err(s_seq_err), .lock_lost(s_lock_lost),
    .err_count(s_err_count), .ovf_count(s_ovf_count),
    .period_meas(s_period_meas), .period_err(s_period_err)
  );

  typedef struct packed {
    logic        locked;
    logic        seq_err;
    logic        lock_lost;
    logic        perr;
    logic [15:0] err;
    logic [3:0]  err4;
    logic [15:0] ovf;
    logic [15:0] pmeas;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_state, m_run, m_miss;
  logic [11:0] m_exp;
  logic [15:0] m_err, m_ovf, m_since, m_pmeas;
  logic [3:0]  m_err4;
  logic        m_armed;

  task automatic model_reset();
    m_state = 0; m_run = 0; m_miss = 0; m_exp = '0;
    m_err = '0; m_ovf = '0; m_since = '0; m_pmeas = '0; m_err4 = '0; m_armed = 1'b0;
    q.delete();
  endtask

  // Drive one cycle of inputs, predict the registered response, push it, advance.
  task automatic step(input logic v, input logic [11:0] c, input logic o,
                      input logic p, input logic cl);
    exp_t e;
    logic match;
    valid_in = v; count_in = c; overflow_in = o; pulse_in = p; clear = cl;
    e = '0;
    match = (c == m_exp);
    case (m_state)
      0: if (v) begin m_exp = c + 12'd1; m_run = 0; m_state = 1; end
      1: if (v) begin
           if (match) begin
             m_run++; m_exp = m_exp + 12'd1;
             if (m_run == 4) begin m_state = 2; m_miss = 0; end
           end else begin
             m_exp = c + 12'd1; m_run = 0;
           end
         end
      2: if (v) begin
           m_exp = m_exp + 12'd1;
           if (match) m_miss = 0;
           else begin
             e.seq_err = 1'b1;
             if (m_err != 16'hFFFF) m_err++;
             if (m_err4 != 4'hF) m_err4++;
             m_miss++;
             if (m_miss == 3) begin m_state = 3; e.lock_lost = 1'b1; end
           end
         end
      default: m_state = 0;
    endcase
    if (v && o && m_ovf != 16'hFFFF) m_ovf++;
    if (v) begin
      if (p) begin
        if (m_armed) begin
          m_pmeas = m_since + 16'd1;
          e.perr = (m_pmeas != 16'd100);
        end
        m_since = '0; m_armed = 1'b1;
      end else if (m_since != 16'hFFFF) begin
        m_since++;
      end
    end
    if (cl) begin
      m_err = '0; m_err4 = '0; m_ovf = '0; m_pmeas = '0; m_since = '0; m_armed = 1'b0;
      e.perr = 1'b0;
    end
    e.locked = (m_state == 2);
    e.err = m_err; e.err4 = m_err4; e.ovf = m_ovf; e.pmeas = m_pmeas;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; count_in = '0; overflow_in = 1'b0;
    pulse_in = 1'b0; clear = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%0b want=0", locked); end
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL reset_seq_err got=%0b want=0", seq_err); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL reset_lock_lost got=%0b want=0", lock_lost); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err_count got=%0h want=0", err_count); end
    checks++; if (ovf_count !== 16'd0) begin failures++; $display("FAIL reset_ovf_count got=%0h want=0", ovf_count); end
    checks++; if (period_meas !== 16'd0) begin failures++; $display("FAIL reset_period_meas got=%0h want=0", period_meas); end
    checks++; if (period_err !== 1'b0) begin failures++; $display("FAIL reset_period_err got=%0b want=0", period_err); end
  endtask

  task automatic test_lock();
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 12'(i), 1'b0, 1'b0, 1'b0);
      e = q.pop_front();
      checks++; if (locked !== e.locked) begin failures++; $display("FAIL lock_model s%0d got=%0b want=%0b", i, locked, e.locked); end
      checks++; if (locked !== (i == 4)) begin failures++; $display("FAIL lock_const s%0d got=%0b want=%0b", i, locked, (i == 4)); end
    end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL lock_err_count got=%0h want=0", err_count); end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [11:0] vals [4];
    vals = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 12'hFF9 + 12'(i), 1'b0, 1'b0, 1'b0);
      void'(q.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      e = q.pop_front();
      checks++; if (seq_err !== 1'b0 || seq_err !== e.seq_err) begin failures++; $display("FAIL wrap_seq_err v=%0h got=%0b want=0", vals[i], seq_err); end
      checks++; if (locked !== 1'b1 || locked !== e.locked) begin failures++; $display("FAIL wrap_locked v=%0h got=%0b want=1", vals[i], locked); end
    end
  endtask

  task automatic test_flywheel();
    exp_t e;
    logic [11:0] vals [3];
    logic        want [3];
    vals = '{12'd10, 12'd99, 12'd12};
    want = '{1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 5; i < 10; i++) begin
      step(1'b1, 12'(i), 1'b0, 1'b0, 1'b0);
      void'(q.pop_front());
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      e = q.pop_front();
      checks++; if (seq_err !== want[i] || seq_err !== e.seq_err) begin failures++; $display("FAIL fly_seq_err v=%0d got=%0b want=%0b", vals[i], seq_err, want[i]); end
      checks++; if (locked !== 1'b1) begin failures++; $display("FAIL fly_locked v=%0d got=%0b want=1", vals[i], locked); end
    end
    checks++; if (err_count !== 16'd1 || err_count !== e.err) begin failures++; $display("FAIL fly_err_count got=%0d want=1", err_count); end
  endtask

  task automatic test_lose_lock();
    exp_t e;
    do_reset();
    for (int i = 20; i < 25; i++) begin
      step(1'b1, 12'(i), 1'b0, 1'b0, 1'b0);
      void'(q.pop_front());
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 12'd100 + 12'(i), 1'b0, 1'b0, 1'b0);
      e = q.pop_front();
      checks++; if (seq_err !== 1'b1 || seq_err !== e.seq_err) begin failures++; $display("FAIL lose_seq_err m%0d got=%0b want=1", i, seq_err); end
      checks++; if (lock_lost !== (i == 2) || lock_lost !== e.lock_lost) begin failures++; $display("FAIL lose_lock_lost m%0d got=%0b want=%0b", i, lock_lost, (i == 2)); end
      checks++; if (locked !== (i != 2) || locked !== e.locked) begin failures++; $display("FAIL lose_locked m%0d got=%0b want=%0b", i, locked, (i != 2)); end
    end
    checks++; if (err_count !== 16'd3) begin failures++; $display("FAIL lose_err_count got=%0d want=3", err_count); end
    // Sample during LOST is dropped; 201 then seeds and 202..205 reacquire.
    for (int i = 200; i < 206; i++) begin
      step(1'b1, 12'(i), 1'b0, 1'b0, 1'b0);
      e = q.pop_front();
      checks++; if (lock_lost !== 1'b0 || seq_err !== 1'b0) begin failures++; $display("FAIL relock_pulses s%0d got=%0b%0b want=00", i, lock_lost, seq_err); end
      checks++; if (locked !== (i == 205) || locked !== e.locked) begin failures++; $display("FAIL relock_locked s%0d got=%0b want=%0b", i, locked, (i == 205)); end
    end
  endtask

  task automatic test_period();
    exp_t e;
    logic p;
    do_reset();
    for (int s = 0; s < 199; s++) begin
      if (s % 50 == 25) begin
        step(1'b0, 12'hABC, 1'b0, 1'b1, 1'b0);
        e = q.pop_front();
        checks++; if (period_meas !== e.pmeas || period_err !== e.perr) begin failures++; $display("FAIL period_hold s%0d got=%0d/%0b want=%0d/%0b", s, period_meas, period_err, e.pmeas, e.perr); end
      end
      p = (s == 0) || (s == 100) || (s == 197);
      step(1'b1, 12'(s), 1'b0, p, 1'b0);
      e = q.pop_front();
      checks++; if (period_meas !== e.pmeas || period_err !== e.perr) begin failures++; $display("FAIL period_model s%0d got=%0d/%0b want=%0d/%0b", s, period_meas, period_err, e.pmeas, e.perr); end
      if (s == 0) begin
        checks++; if (period_meas !== 16'd0 || period_err !== 1'b0) begin failures++; $display("FAIL period_first got=%0d/%0b want=0/0", period_meas, period_err); end
      end
      if (s == 100) begin
        checks++; if (period_meas !== 16'd100 || period_err !== 1'b0) begin failures++; $display("FAIL period_100 got=%0d/%0b want=100/0", period_meas, period_err); end
      end
      if (s == 197) begin
        checks++; if (period_meas !== 16'd97 || period_err !== 1'b1) begin failures++; $display("FAIL period_97 got=%0d/%0b want=97/1", period_meas, period_err); end
      end
      if (s == 198) begin
        checks++; if (period_err !== 1'b0) begin failures++; $display("FAIL period_err_pulse got=%0b want=0", period_err); end
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    logic        v_t [7];
    logic        o_t [7];
    logic        c_t [7];
    logic [15:0] w_t [7];
    v_t = '{1, 0, 1, 1, 1, 0, 1};
    o_t = '{1, 1, 0, 1, 1, 0, 1};
    c_t = '{0, 0, 0, 0, 0, 0, 1};
    w_t = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd3, 16'd0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(v_t[i], 12'(i), o_t[i], 1'b0, c_t[i]);
      e = q.pop_front();
      checks++; if (ovf_count !== w_t[i] || ovf_count !== e.ovf) begin failures++; $display("FAIL ovf c%0d got=%0d want=%0d", i, ovf_count, w_t[i]); end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [11:0] nxt;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 12'(i), 1'b0, 1'b0, 1'b0);
      void'(q.pop_front());
    end
    nxt = 12'd5;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b1, (k == 2) ? nxt : (nxt ^ 12'h800), 1'b0, 1'b0, 1'b0);
        nxt = nxt + 12'd1;
        e = q.pop_front();
        checks++; if (err_count !== e.err || s_err_count !== e.err4) begin failures++; $display("FAIL sat_model r%0d k%0d got=%0d/%0d want=%0d/%0d", r, k, err_count, s_err_count, e.err, e.err4); end
      end
    end
    checks++; if (err_count !== 16'd16 || s_err_count !== 4'hF) begin failures++; $display("FAIL sat_reach got=%0d/%0h want=16/f", err_count, s_err_count); end
    step(1'b1, nxt ^ 12'h800, 1'b0, 1'b0, 1'b0);
    nxt = nxt + 12'd1;
    e = q.pop_front();
    checks++; if (s_err_count !== 4'hF || err_count !== 16'd17) begin failures++; $display("FAIL sat_hold got=%0d/%0h want=17/f", err_count, s_err_count); end
    checks++; if (s_locked !== 1'b1 || locked !== e.locked) begin failures++; $display("FAIL sat_locked got=%0b/%0b want=1/1", s_locked, locked); end
    step(1'b1, nxt ^ 12'h800, 1'b0, 1'b0, 1'b1);
    e = q.pop_front();
    checks++; if (err_count !== 16'd0 || s_err_count !== 4'd0 || err_count !== e.err) begin failures++; $display("FAIL clear_err got=%0d/%0d want=0/0", err_count, s_err_count); end
    checks++; if (seq_err !== 1'b1 || s_seq_err !== 1'b1) begin failures++; $display("FAIL clear_seq_err got=%0b/%0b want=1/1", seq_err, s_seq_err); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL clear_locked got=%0b want=1", locked); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 12'(i), 1'b1, 1'b0, 1'b0);
      void'(q.pop_front());
    end
    checks++; if (locked !== 1'b1 || ovf_count !== 16'd5) begin failures++; $display("FAIL mid_pre got=%0b/%0d want=1/5", locked, ovf_count); end
    do_reset();
    checks++; if (locked !== 1'b0 || lock_lost !== 1'b0 || ovf_count !== 16'd0) begin failures++; $display("FAIL mid_reset got=%0b/%0b/%0d want=0/0/0", locked, lock_lost, ovf_count); end
    step(1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
    void'(q.pop_front());
    checks++; if (lock_lost !== 1'b0 || locked !== 1'b0) begin failures++; $display("FAIL mid_after got=%0b/%0b want=0/0", lock_lost, locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_flywheel();
    test_lose_lock();
    test_period();
    test_overflow();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
